// File: rtl/frame_max_tracker_pkg.sv
// frame_max_tracker_pkg: shared state encoding and sample width for the frame max tracker
package frame_max_tracker_pkg;
    localparam int DATA_W = 4;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;
endpackage

// File: rtl/frame_max_tracker_gt.sv
// four_bit_greater_than: unsigned strict a > b comparator for 4-bit samples
module four_bit_greater_than
    import frame_max_tracker_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              gt
);
    assign gt = a > b;
endmodule

// File: rtl/frame_max_tracker.sv
// frame_max_tracker: per-frame running maximum, first-occurrence index, count and truncation flag
module frame_max_tracker
    import frame_max_tracker_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int IDX_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W:0]    out_count,
    output logic              out_trunc
);
    localparam logic [IDX_W:0] LEN = (IDX_W+1)'(MAX_LEN);

    state_t            state;
    logic [DATA_W-1:0] max_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W:0]    cnt_q;
    logic              trunc_q;
    logic              gt;
    logic [IDX_W:0]    cnt_nxt;
    logic              full_nxt;
    logic              one_len;

    four_bit_greater_than u_gt (.a(in_data), .b(max_q), .gt(gt));

    assign cnt_nxt  = cnt_q + 1'b1;
    assign full_nxt = cnt_nxt == LEN;
    assign one_len  = LEN == 1;
    assign in_ready = (state == ST_IDLE) || (state == ST_ACCUM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_valid) begin
                    max_q   <= in_data;
                    idx_q   <= '0;
                    cnt_q   <= 1;
                    trunc_q <= ~in_last & one_len;
                    state   <= (in_last || one_len) ? ST_HOLD : ST_ACCUM;
                end
                ST_ACCUM: if (in_valid) begin
                    // strict compare keeps the earliest index on ties
                    if (gt) begin
                        max_q <= in_data;
                        idx_q <= cnt_q[IDX_W-1:0];
                    end
                    cnt_q   <= cnt_nxt;
                    trunc_q <= ~in_last & full_nxt;
                    state   <= (in_last || full_nxt) ? ST_HOLD : ST_ACCUM;
                end
                ST_HOLD: if (out_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = state == ST_HOLD;
    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_count = cnt_q;
    assign out_trunc = trunc_q;
endmodule

// File: tb/tb_frame_max_tracker.sv
// tb_frame_max_tracker: directed frames with hand-computed results for frame_max_tracker
module tb_frame_max_tracker;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       in_valid = 0;
    logic [3:0] in_data = 0;
    logic       in_last = 0;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready = 0;
    logic [3:0] out_max;
    logic [3:0] out_idx;
    logic [4:0] out_count;
    logic       out_trunc;
    int         n_cmp = 0;
    int         n_bad = 0;

    frame_max_tracker #(.MAX_LEN(16), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_max(out_max), .out_idx(out_idx),
        .out_count(out_count), .out_trunc(out_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive one sample at a negedge, return at the negedge after it is accepted
    task automatic send(input logic [3:0] d, input logic l);
        int n = 0;
        in_valid = 1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("send_timeout", 0, 1);
        @(negedge clk);
        in_valid = 0;
        in_last  = 0;
    endtask

    task automatic result(input string tag, input int m, input int i, input int c, input int t);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_max"}, out_max, m);
        chk({tag, "_idx"}, out_idx, i);
        chk({tag, "_count"}, out_count, c);
        chk({tag, "_trunc"}, out_trunc, t);
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk({tag, "_drop"}, out_valid, 0);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_max", out_max, 0);
        chk("rst_count", out_count, 0);
        chk("rst_trunc", out_trunc, 0);
        rst_n = 1;
        @(negedge clk);
        chk("idle_ready", in_ready, 1);

        send(3, 0); send(9, 0); send(2, 0); send(9, 1);
        result("t1", 9, 1, 4, 0);

        @(negedge clk);
        send(7, 1);
        chk("t2_latency", out_valid, 1);
        result("t2", 7, 0, 1, 0);

        for (int k = 0; k < 16; k++) send(4'(k), 0);
        chk("t3_ready_hold", in_ready, 0);
        chk("t3_valid", out_valid, 1);
        chk("t3_max", out_max, 15);
        chk("t3_idx", out_idx, 15);
        chk("t3_count", out_count, 16);
        chk("t3_trunc", out_trunc, 1);

        in_valid = 1; in_data = 3; in_last = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_hold_valid", out_valid, 1);
            chk("t4_hold_max", out_max, 15);
            chk("t4_hold_count", out_count, 16);
            chk("t4_hold_ready", in_ready, 0);
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        chk("t4_idle_valid", out_valid, 0);
        chk("t4_idle_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 0; in_last = 0;
        result("t4", 3, 0, 1, 0);

        @(negedge clk);
        send(0, 0); send(0, 0); send(0, 1);
        result("t5", 0, 0, 3, 0);

        @(negedge clk);
        send(4, 0); send(2, 0); send(4, 0); send(1, 1);
        result("tie", 4, 0, 4, 0);

        @(negedge clk);
        for (int k = 0; k < 16; k++) send(4'(k == 5 ? 12 : 1), k == 15);
        result("last_on_full", 12, 5, 16, 0);

        @(negedge clk);
        send(8, 0); send(1, 0);
        rst_n = 0;
        @(negedge clk);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_count", out_count, 0);
        rst_n = 1;
        @(negedge clk);
        chk("t6_no_result", out_valid, 0);
        send(5, 1);
        result("t6", 5, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
